// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access codes, FSM states,
// byte-enable and alignment helpers.
package lsu_pkg;

   localparam logic [2:0] MEM_NONE = 3'b000;
   localparam logic [2:0] MEM_B    = 3'b001;
   localparam logic [2:0] MEM_H    = 3'b010;
   localparam logic [2:0] MEM_W    = 3'b011;
   localparam logic [2:0] MEM_BU   = 3'b101;
   localparam logic [2:0] MEM_HU   = 3'b110;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

   function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lane);
      case (op)
         MEM_B, MEM_BU: byte_en = 4'b0001 << lane;
         MEM_H, MEM_HU: byte_en = 4'b0011 << lane;
         MEM_W:         byte_en = 4'b1111;
         default:       byte_en = 4'b0000;
      endcase
   endfunction

   // Unknown codes report as misaligned so they fault instead of touching memory.
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
      case (op)
         MEM_B, MEM_BU: misaligned = 1'b0;
         MEM_H, MEM_HU: misaligned = lane[0];
         MEM_W:         misaligned = (lane != 2'b00);
         default:       misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-lane select and sign/zero extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] dmem_rdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  mem_op,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = dmem_rdata >> {lane, 3'b000};
      case (mem_op)
         MEM_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
         MEM_BU:  ld_data = {24'h0, shifted[7:0]};
         MEM_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
         MEM_HU:  ld_data = {16'h0, shifted[15:0]};
         default: ld_data = dmem_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: req/gnt/rvalid handshake, lane shifting, load extension.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_t  state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic        accept, flt, ld_done, tmo;
  logic [31:0] ld_data;

  lsu_load_align u_align (
    .dmem_rdata (dmem_rdata),
    .lane       (lane_q),
    .mem_op     (op_q),
    .ld_data    (ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (accept)
      cnt <= '0;
    else if (state == REQ || state == WAIT)
      cnt <= cnt + 8'd1;
  end

  assign tmo = (state == REQ || state == WAIT) && (cnt == LIMIT);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    flt       = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (mem_op == MEM_NONE)
          state_nxt = DONE;
        else if (misaligned(mem_op, addr[1:0]))
          flt = 1'b1;
        else begin
          state_nxt = REQ;
          accept    = 1'b1;
        end
      end
      REQ: if (dmem_gnt)
             state_nxt = dmem_we ? DONE : WAIT;
           else if (tmo) begin
             state_nxt = IDLE;
             flt       = 1'b1;
           end
      WAIT: if (dmem_rvalid) begin
              state_nxt = DONE;
              ld_done   = 1'b1;
            end else if (tmo) begin
              state_nxt = IDLE;
              flt       = 1'b1;
            end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= MEM_NONE;
      lane_q     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      rdata      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      fault    <= flt;
      dmem_req <= (state_nxt == REQ);
      if (accept) begin
        op_q       <= mem_op;
        lane_q     <= addr[1:0];
        dmem_we    <= is_store;
        dmem_addr  <= {addr[31:2], 2'b00};
        dmem_be    <= byte_en(mem_op, addr[1:0]);
        dmem_wdata <= wdata << {addr[1:0], 3'b000};
      end
      if (ld_done)
        rdata <= ld_data;
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the 32-bit core's memory stage. It consumes the memory-access code produced by the ALU control decoder, plus the ALU result as the effective address and rs2 as store data. It runs a request/grant/response handshake with the data memory, then returns sign- or zero-extended load data to writeback. It sits directly downstream of the ALU and ALU control, and upstream of the register-file writeback mux.

## Interface
- `TIMEOUT`, 255: watchdog limit in cycles; used only when `LSU_TIMEOUT_EN` is defined.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle command strobe from the pipeline.
- `is_store`  in  1  1 = store, 0 = load.
- `mem_op`  in  3  access code: 000 none, 001 byte, 010 half, 011 word, 101 byte-unsigned, 110 half-unsigned.
- `addr`  in  32  effective address (ALU result).
- `wdata`  in  32  store data (rs2), right-aligned.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  one-cycle pulse on misalignment or timeout.
- `rdata`  out  32  extended load data; holds until the next load completes.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  32  word address; bits [1:0] are always 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-shifted store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read data.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE, start with mem_op = none:** go to DONE with no memory access; `rdata` is unchanged.
- **IDLE, start with a misaligned access:** a half access is misaligned when `addr[0]` = 1; a word access when `addr[1:0]` ≠ 0. Pulse `fault` next cycle and stay in IDLE.
- **IDLE, start with a valid access:** latch the command and go to REQ.
- **`start` while busy:** ignored.
- **REQ:** hold `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` stable until `dmem_gnt`. On grant, a store goes to DONE and a load goes to WAIT.
- **WAIT:** on `dmem_rvalid`, extract the lane selected by `addr[1:0]`, extend it, register it into `rdata`, and go to DONE.
- **DONE:** `done` = 1 for one cycle, then return to IDLE.
- **Byte enables:** byte → `4'b0001 << addr[1:0]`; half → `4'b0011 << addr[1:0]`; word → `4'b1111`.
- **Store data:** `dmem_wdata` = `wdata << (8*addr[1:0])`.
- **Load extension:** codes 001 and 010 sign-extend from bit 7 or bit 15; codes 101 and 110 zero-extend; word is passed through.
- **Unknown mem_op codes (100, 111):** treated as a misaligned fault.

## Timing
- **Reset:** state IDLE; all outputs 0, including `rdata`.
- **Reset mid-transaction:** drops `dmem_req` immediately (asynchronous); no `done` or `fault` is issued.
- **Best-case load latency:** `start` at cycle 0, REQ in cycle 1 with `dmem_gnt`, WAIT in cycle 2 with `dmem_rvalid`, `done` and valid `rdata` in cycle 3.
- **Best-case store latency:** `done` in cycle 2.
- **`dmem_rvalid` arriving in REQ:** ignored. Memory must return `dmem_rvalid` at least one cycle after `dmem_gnt`.
- **Outputs:** all outputs are registered; `dmem_req` falls in the cycle after the grant.
- **`fault` and `done`:** never high in the same cycle.

## Configuration
- **With `LSU_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - On reaching `TIMEOUT`, pulse `fault`, deassert `dmem_req`, and return to IDLE without `done`.
  - A grant or rvalid arriving in the same cycle as the limit wins over the timeout.
- **Without it:** no counter is built; the unit waits indefinitely.

## Structure
- **Shared package `lsu_pkg`:**
  - `mem_op` encoding constants `MEM_NONE`, `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`.
  - State enum.
  - Functions for byte-enable generation and misalignment check.
- **Sub-module `lsu_load_align`:** combinational lane select and extension, taking `dmem_rdata`, `addr[1:0]` and `mem_op`.
- **Top level:** owns the FSM, latches and watchdog.

## Test plan
- **LB, sign path:** `addr` = 0x103, `dmem_rdata` = 0x80FF_FF7F, gnt in REQ, rvalid next cycle → `dmem_be` = 1000, `dmem_addr` = 0x100, `rdata` = 0xFFFF_FF80, `done` in cycle 3.
- **LHU:** `addr` = 0x22, `dmem_rdata` = 0xBEEF_1234 → `dmem_be` = 1100, `rdata` = 0x0000_BEEF.
- **SB with stalled grant:** `addr` = 0x41, `wdata` = 0xAB, gnt delayed 4 cycles → request signals stable throughout, `dmem_wdata` = 0x0000_AB00, `dmem_be` = 0010, `done` 1 cycle after grant.
- **Misaligned LW:** `addr` = 0x6 → `fault` pulse in cycle 1, `dmem_req` never asserted, `busy` stays 0.
- **Timeout (with `LSU_TIMEOUT_EN`, `TIMEOUT` = 8):** no gnt → `fault` after 8 cycles in REQ, `dmem_req` deasserted, no `done`; without the macro, `busy` stays high.
- **Reset in WAIT, then back-to-back commands:** assert `rst` in WAIT → `dmem_req` and `busy` are 0 at once, and a following LW completes normally.
